// File: rtl/avalon_bus_decoder.sv
// Single-master Avalon-MM address decoder and response router.
// Top address bits pick the slave; read data comes back registered, and unmapped or hung accesses complete with an error.
module avalon_bus_decoder #(
  parameter int ADDR_SEL_BITS = 6,
  parameter int NUM_SLAVES    = 4,
  parameter int TIMEOUT       = 256
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst,
  input  logic [29:0]                 i_M_Address,
  input  logic                        i_M_Read,
  input  logic                        i_M_Write,
  input  logic [31:0]                 i_M_WriteData,
  input  logic [3:0]                  i_M_ByteEnable,
  output logic [31:0]                 o_M_ReadData,
  output logic                        o_M_ReadDataValid,
  output logic                        o_M_WaitRequest,
  output logic                        o_M_Error,
  output logic [NUM_SLAVES-1:0]       o_SlaveSel,
  output logic [29-ADDR_SEL_BITS:0]   o_RegAddr,
  output logic                        o_S_Read,
  output logic                        o_S_Write,
  output logic [31:0]                 o_S_WriteData,
  output logic [3:0]                  o_S_ByteEnable,
  input  logic [32*NUM_SLAVES-1:0]    i_S_ReadData,
  input  logic [NUM_SLAVES-1:0]       i_S_WaitRequest
);

  localparam int   CNT_W         = $clog2(TIMEOUT) + 1;
  localparam logic STATE_IDLE    = 1'b0;
  localparam logic STATE_RD_DATA = 1'b1;

  logic                     state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ADDR_SEL_BITS-1:0] idxLat_q, idxLat_d;
  logic                     errLat_q, errLat_d;
  logic [31:0]              readData_q, readData_d;
  logic                     rdValid_q, rdValid_d;
  logic                     err_q, err_d;

  logic [ADDR_SEL_BITS-1:0] idx;
  logic                     req;
  logic                     mapped;
  logic                     slvWait;
  logic [31:0]              rdSlice;
  logic                     stalled;
  logic                     timeoutFire;
  logic                     accept;
  logic                     errFlag;
  logic                     slaveActive;

  assign idx    = i_M_Address[29 -: ADDR_SEL_BITS];
  assign req    = i_M_Read | i_M_Write;
  assign mapped = 32'(idx) < 32'(NUM_SLAVES);

  always_comb begin
    slvWait = 1'b0;
    rdSlice = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (32'(idx) == k) slvWait = i_S_WaitRequest[k];
      if (32'(idxLat_q) == k) rdSlice = i_S_ReadData[32*k +: 32];
    end
  end

  // A stall that reaches TIMEOUT-1 counted cycles is forced through as an error accept.
  assign stalled     = !i_Rst && (state_q == STATE_IDLE) && req && mapped && slvWait;
  assign timeoutFire = (TIMEOUT != 0) && stalled && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign cnt_d       = (stalled && !timeoutFire) ? cnt_q + 1'b1 : '0;

  assign o_M_WaitRequest = i_Rst || (state_q == STATE_RD_DATA) || (stalled && !timeoutFire);
  assign accept          = (state_q == STATE_IDLE) && req && !o_M_WaitRequest;
  assign errFlag         = !mapped || timeoutFire;
  assign slaveActive     = !i_Rst && (state_q == STATE_IDLE) && req && mapped && !timeoutFire;

  always_comb begin
    o_SlaveSel = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      o_SlaveSel[k] = slaveActive && (32'(idx) == k);
    end
  end

  assign o_S_Read       = slaveActive && i_M_Read;
  assign o_S_Write      = slaveActive && i_M_Write && !i_M_Read;
  assign o_S_WriteData  = i_M_WriteData;
  assign o_S_ByteEnable = i_M_ByteEnable;
  assign o_RegAddr      = i_M_Address[29-ADDR_SEL_BITS:0];

  // Reads spend one cycle in RD_DATA while the slave presents data; writes complete in IDLE.
  always_comb begin
    state_d    = state_q;
    idxLat_d   = idxLat_q;
    errLat_d   = errLat_q;
    readData_d = readData_q;
    rdValid_d  = 1'b0;
    err_d      = 1'b0;
    if (state_q == STATE_RD_DATA) begin
      readData_d = errLat_q ? 32'h0 : rdSlice;
      rdValid_d  = 1'b1;
      err_d      = errLat_q;
      state_d    = STATE_IDLE;
    end else if (accept) begin
      if (i_M_Read) begin
        state_d  = STATE_RD_DATA;
        idxLat_d = idx;
        errLat_d = errFlag;
      end else begin
        err_d = errFlag;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= STATE_IDLE;
      cnt_q      <= '0;
      idxLat_q   <= '0;
      errLat_q   <= 1'b0;
      readData_q <= '0;
      rdValid_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idxLat_q   <= idxLat_d;
      errLat_q   <= errLat_d;
      readData_q <= readData_d;
      rdValid_q  <= rdValid_d;
      err_q      <= err_d;
    end
  end

  assign o_M_ReadData      = readData_q;
  assign o_M_ReadDataValid = rdValid_q;
  assign o_M_Error         = err_q;

endmodule

// File: tb/tb_avalon_bus_decoder.sv
// Self-checking bench for avalon_bus_decoder: directed cases plus random transactions
// checked against a transaction-level reference of the decode, stall, timeout and memory contents.
module tb_avalon_bus_decoder;

  localparam int ASB = 6;
  localparam int NS  = 4;
  localparam int TO  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [29:0]     mAddr;
  logic            mRead;
  logic            mWrite;
  logic [31:0]     mWData;
  logic [3:0]      mBE;
  logic [31:0]     mRData;
  logic            mRValid;
  logic            mWait;
  logic            mErr;
  logic [NS-1:0]   sSel;
  logic [23:0]     regAddr;
  logic            sRead;
  logic            sWrite;
  logic [31:0]     sWData;
  logic [3:0]      sBE;
  logic [32*NS-1:0] sRData;
  logic [NS-1:0]   sWait;

  int total = 0;
  int bad   = 0;

  logic [31:0] seedMem [NS][16];
  logic [31:0] refMem  [NS][16];
  logic [31:0] slvMem  [NS][16];
  logic [31:0] sRd     [NS];
  logic        loadMem;

  always #5 clk = ~clk;

  avalon_bus_decoder #(
    .ADDR_SEL_BITS(ASB),
    .NUM_SLAVES(NS),
    .TIMEOUT(TO)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .i_M_Address(mAddr),
    .i_M_Read(mRead),
    .i_M_Write(mWrite),
    .i_M_WriteData(mWData),
    .i_M_ByteEnable(mBE),
    .o_M_ReadData(mRData),
    .o_M_ReadDataValid(mRValid),
    .o_M_WaitRequest(mWait),
    .o_M_Error(mErr),
    .o_SlaveSel(sSel),
    .o_RegAddr(regAddr),
    .o_S_Read(sRead),
    .o_S_Write(sWrite),
    .o_S_WriteData(sWData),
    .o_S_ByteEnable(sBE),
    .i_S_ReadData(sRData),
    .i_S_WaitRequest(sWait)
  );

  for (genvar k = 0; k < NS; k++) begin : gSlaveData
    assign sRData[32*k +: 32] = sRd[k];
  end

  // Slave bus models: 1-cycle read latency, drive 0 when not reading; slave 0 is a ROM.
  always @(posedge clk) begin
    for (int k = 0; k < NS; k++) begin
      if (loadMem) begin
        for (int j = 0; j < 16; j++) slvMem[k][j] <= seedMem[k][j];
        sRd[k] <= '0;
      end else begin
        if (sSel[k] && sRead && !sWait[k]) sRd[k] <= slvMem[k][regAddr[3:0]];
        else sRd[k] <= '0;
        if (sSel[k] && sWrite && !sWait[k] && k != 0) slvMem[k][regAddr[3:0]] <= sWData;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One master transaction; starts just after a falling edge and leaves a write request still driven.
  task automatic applyStimulus(input logic isRd, input logic isWr, input logic [5:0] idx,
                               input logic [23:0] regA, input logic [31:0] wd,
                               input logic [3:0] be, input int stalls);
    logic          mapped;
    logic          timedOut;
    logic          err;
    logic          expActive;
    logic [NS-1:0] oneHot;
    logic [31:0]   expData;
    int            accAt;
    mapped   = idx < NS;
    timedOut = mapped && (stalls >= TO);
    err      = !mapped || timedOut;
    accAt    = timedOut ? TO - 1 : (mapped ? stalls : 0);
    oneHot   = mapped ? (NS'(1) << idx) : '0;
    mAddr  = {idx, regA};
    mRead  = isRd;
    mWrite = isWr;
    mWData = wd;
    mBE    = be;
    for (int c = 0; c <= accAt; c++) begin
      sWait = (mapped && c < stalls) ? oneHot : '0;
      #1;
      expActive = mapped && !(timedOut && c == accAt);
      checkOutput("waitReq", mWait, c < accAt);
      checkOutput("slaveSel", sSel, expActive ? oneHot : '0);
      checkOutput("sRead", sRead, expActive && isRd);
      checkOutput("sWrite", sWrite, expActive && isWr && !isRd);
      if (c == accAt) begin
        checkOutput("regAddr", regAddr, regA);
        checkOutput("sWData", sWData, wd);
        checkOutput("sBE", sBE, be);
      end
      @(negedge clk);
    end
    sWait = '0;
    if (isRd) begin
      mRead  = 1'b0;
      mWrite = 1'b0;
      #1;
      checkOutput("rdPhaseWait", mWait, 1);
      checkOutput("rdPhaseValid", mRValid, 0);
      checkOutput("rdPhaseSel", sSel, '0);
      @(negedge clk);
      #1;
      expData = '0;
      if (!err) expData = refMem[idx[1:0]][regA[3:0]];
      checkOutput("rdValid", mRValid, 1);
      checkOutput("rdData", mRData, expData);
      checkOutput("rdErr", mErr, err);
    end else begin
      #1;
      checkOutput("wrErr", mErr, err);
      checkOutput("wrValid", mRValid, 0);
      if (!err && idx != 0) refMem[idx[1:0]][regA[3:0]] = wd;
    end
  endtask

  task automatic idleCycle();
    mRead  = 1'b0;
    mWrite = 1'b0;
    sWait  = '0;
    @(negedge clk);
    #1;
    checkOutput("idleWait", mWait, 0);
    checkOutput("idleValid", mRValid, 0);
    checkOutput("idleErr", mErr, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    int stalls;
    int op;
    logic [5:0] idx;
    for (int k = 0; k < NS; k++)
      for (int j = 0; j < 16; j++) seedMem[k][j] = $urandom;
    seedMem[0][3] = 32'h00239A95;
    seedMem[2][0] = 32'hCAFEF00D;
    for (int k = 0; k < NS; k++)
      for (int j = 0; j < 16; j++) refMem[k][j] = seedMem[k][j];

    loadMem = 1'b1;
    rst     = 1'b1;
    mAddr   = {6'd0, 24'd3};
    mRead   = 1'b1;
    mWrite  = 1'b0;
    mWData  = '0;
    mBE     = '0;
    sWait   = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstWait", mWait, 1);
    checkOutput("rstSel", sSel, '0);
    checkOutput("rstSRead", sRead, 0);
    checkOutput("rstValid", mRValid, 0);
    checkOutput("rstErr", mErr, 0);
    checkOutput("rstData", mRData, 0);
    rst     = 1'b0;
    loadMem = 1'b0;
    mRead   = 1'b0;

    // ROM read, back-to-back writes to slave 1 and read-back, unmapped read
    applyStimulus(1, 0, 6'd0, 24'd3, 0, 4'hF, 0);
    idleCycle();
    applyStimulus(0, 1, 6'd1, 24'd0, 32'h11110000, 4'hF, 0);
    applyStimulus(0, 1, 6'd1, 24'd1, 32'h11110001, 4'h3, 0);
    applyStimulus(0, 1, 6'd1, 24'd2, 32'h11110002, 4'hC, 0);
    idleCycle();
    applyStimulus(1, 0, 6'd1, 24'd1, 0, 4'hF, 0);
    applyStimulus(1, 0, 6'd63, 24'd0, 0, 4'hF, 0);

    // Stalled slave, then a slave that never releases
    applyStimulus(1, 0, 6'd2, 24'd0, 0, 4'hF, 3);
    applyStimulus(1, 0, 6'd2, 24'd0, 0, 4'hF, 1000);
    applyStimulus(1, 0, 6'd2, 24'd0, 0, 4'hF, TO - 1);
    idleCycle();

    // Reset arriving in the RD_DATA cycle discards the read
    mAddr = {6'd0, 24'd3};
    mRead = 1'b1;
    @(negedge clk);
    rst   = 1'b1;
    mRead = 1'b0;
    #1;
    checkOutput("rdRstWait", mWait, 1);
    checkOutput("rdRstSel", sSel, '0);
    @(negedge clk);
    #1;
    checkOutput("rdRstValid", mRValid, 0);
    checkOutput("rdRstData", mRData, 0);
    checkOutput("rdRstErr", mErr, 0);
    rst = 1'b0;
    applyStimulus(1, 0, 6'd0, 24'd3, 0, 4'hF, 0);

    // Read and write together, unmapped write, timed-out write
    applyStimulus(1, 1, 6'd0, 24'd3, 32'hDEADBEEF, 4'hF, 0);
    applyStimulus(0, 1, 6'd40, 24'd5, 32'h12345678, 4'hF, 0);
    applyStimulus(0, 1, 6'd3, 24'd7, 32'h87654321, 4'hF, 50);
    idleCycle();
    applyStimulus(1, 0, 6'd3, 24'd7, 0, 4'hF, 0);

    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7) idx = 6'(r % NS);
      else if (r == 7) idx = 6'd63;
      else idx = 6'($urandom_range(NS, 62));
      r = $urandom_range(0, 9);
      stalls = (r < 6) ? 0 : (r < 9) ? $urandom_range(1, TO - 1) : $urandom_range(TO, 20);
      op = $urandom_range(0, 3);
      applyStimulus(op != 2, op >= 2, idx, 24'($urandom), $urandom, 4'($urandom), stalls);
      if ($urandom_range(0, 1) == 1) idleCycle();
    end
    idleCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
